// File: rtl/dpb_pkg.sv
// dpb_pkg: shared widths, defaults and state type for the DPB RAM port controller
package dpb_pkg;
    localparam int ADDR_W_DEF = 11;
    localparam int DATA_W_DEF = 8;
    localparam int RAM_DEPTH  = 1 << ADDR_W_DEF;
    localparam int ADA_W      = 14;
    localparam int DIA_W      = 18;
    localparam int BLK_W      = 3;
    localparam int DOA_W      = 8;
    typedef enum logic {ST_CLEAR, ST_RUN} state_e;
endpackage

// File: rtl/dpb_rsp_fifo.sv
// dpb_rsp_fifo: two-entry read-response FIFO, head always held in slot 0
module dpb_rsp_fifo #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic [1:0]   count_o
);
    logic [W-1:0] e0_q, e0_d, e1_q, e1_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         pop;
    // pop shifts slot 1 into the head, then a push fills the lowest free slot
    always_comb begin
        pop   = pop_i && cnt_q != 2'd0;
        e0_d  = pop ? e1_q : e0_q;
        e1_d  = e1_q;
        cnt_d = cnt_q - {1'b0, pop};
        if (push_i && cnt_d != 2'd2) begin
            if (cnt_d == 2'd0) e0_d = din_i;
            else e1_d = din_i;
            cnt_d = cnt_d + 2'd1;
        end
    end
    // storage and occupancy registers, cleared so the head is never X
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= '0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
        end
    end
    assign dout_o  = e0_q;
    assign count_o = cnt_q;
endmodule

// File: rtl/dpb_port_ctrl.sv
// dpb_port_ctrl: host command port onto a single-port block RAM with a 2-deep response FIFO.
// Optional power-up clear of the whole RAM is built when DPB_PORT_CTRL_CLEAR_EN is defined.
module dpb_port_ctrl
    import dpb_pkg::*;
#(
    parameter int                ADDR_W      = ADDR_W_DEF,
    parameter int                DATA_W      = DATA_W_DEF,
    parameter logic [BLK_W-1:0]  BLKSEL      = 3'b000,
    parameter logic [DATA_W-1:0] CLEAR_VALUE = 8'h00
) (
    input  logic              CLKA,
    input  logic              RESETB,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              CEA,
    output logic              OCEA,
    output logic              WREA,
    output logic              RESETA,
    output logic [ADA_W-1:0]  ADA,
    output logic [DIA_W-1:0]  DIA,
    output logic [BLK_W-1:0]  BLKSELA,
    input  logic [DOA_W-1:0]  DOA
);
    logic              run, acc, pop, rd_q, rd_d;
    logic [1:0]        cnt;
    logic [DATA_W-1:0] head;
    logic [ADDR_W-1:0] clr_addr;
`ifdef DPB_PORT_CTRL_CLEAR_EN
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_q, clr_d;
    // state and clear-address registers; any reset restarts the clear at address 0
    always_ff @(posedge CLKA) begin
        if (RESETB) begin
            state_q <= ST_CLEAR;
            clr_q   <= '0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
        end
    end
    // walk every address once, then hand the port to the host
    always_comb begin
        state_d = state_q;
        clr_d   = clr_q;
        if (state_q == ST_CLEAR) begin
            clr_d = clr_q + ADDR_W'(1);
            if (&clr_q) state_d = ST_RUN;
        end
    end
    assign run      = state_q == ST_RUN;
    assign clr_addr = clr_q;
`else
    assign run      = 1'b1;
    assign clr_addr = '0;
`endif
    // occupancy plus the in-flight read bounds outstanding reads to the FIFO depth
    assign req_ready = !RESETB && run && (cnt + {1'b0, rd_q}) < 2'd2;
    assign acc       = req_valid && req_ready;
    assign CEA       = !RESETB && (run ? acc : 1'b1);
    assign WREA      = !RESETB && (run ? acc && req_we : 1'b1);
    assign OCEA      = acc && !req_we;
    assign RESETA    = RESETB;
    assign ADA       = ADA_W'(run ? req_addr : clr_addr);
    assign DIA       = DIA_W'(run ? req_wdata : CLEAR_VALUE);
    assign BLKSELA   = BLKSEL;
    assign rsp_valid = !RESETB && cnt != 2'd0;
    assign rsp_data  = RESETB ? '0 : head;
    assign pop       = rsp_valid && rsp_ready;
    assign rd_d      = acc && !req_we;
    // marks a read whose word appears on the RAM output register next cycle
    always_ff @(posedge CLKA) begin
        if (RESETB) rd_q <= 1'b0;
        else rd_q <= rd_d;
    end
    dpb_rsp_fifo #(.W(DATA_W)) u_fifo (
        .clk_i   (CLKA),
        .rst_i   (RESETB),
        .push_i  (rd_q),
        .pop_i   (pop),
        .din_i   (DOA[DATA_W-1:0]),
        .dout_o  (head),
        .count_o (cnt)
    );
endmodule
